fir_decimator_mac: RTL and testbench

- Parametrised successor to the fixed 16-bit decimating FIR stages in the mic chain: PDM-derived audio → decimator cascade → hanning_window → fft.
- Generalised in data width, coefficient width, tap count and decimation ratio.
- Uses a single time-multiplexed multiply-accumulate, computing only on output phases.
- Adds run-time loadable coefficients, rounding and saturation, a busy indicator and a sticky overrun flag.

---
 rtl/fir_decimator_mac.sv | 135 +++++++++++++
 tb/tb_fir_decimator_mac.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator_mac.sv
// Decimating FIR with one time-multiplexed MAC; runs only on output phases.
// Latency NUM_TAPS+2 cycles from trigger sample to dec_output_ready; samples arriving while busy are dropped and flagged.
module fir_decimator_mac #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 15,
    parameter int NUM_TAPS    = 32,
    parameter int DECIMATION  = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [DATA_WIDTH-1:0]        audio_in,
    input  logic                         audio_sample_valid,
    input  logic                         coef_we_in,
    input  logic [$clog2(NUM_TAPS)-1:0]  coef_addr_in,
    input  logic [COEFF_WIDTH-1:0]       coef_data_in,
    output logic [DATA_WIDTH-1:0]        dec_output,
    output logic                         dec_output_ready,
    output logic                         busy_out,
    output logic                         overrun_out
);

    localparam int AW    = $clog2(NUM_TAPS);
    localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W = PW + AW;
    localparam int PHW   = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    localparam logic [COEFF_WIDTH-1:0] COEF_RESET = COEFF_WIDTH'((1 << COEFF_FRAC) / NUM_TAPS);
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEFF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0]  samples [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] coefs   [NUM_TAPS];
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 tap;
    logic [AW-1:0]                 rd_idx;
    logic [PHW-1:0]                phase;
    logic signed [ACC_W-1:0]       acc;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_W-1:0]       acc_rnd;
    logic signed [ACC_W-1:0]       acc_shr;
    logic [DATA_WIDTH-1:0]         sat;
    logic                          accept;
    logic                          trigger;
    logic                          coef_wr;

    assign accept  = audio_sample_valid && (state == IDLE);
    assign trigger = accept && (phase == PHW'(DECIMATION - 1));
    assign coef_wr = coef_we_in && (state == IDLE);

    // wr_ptr already points past the newest sample, so x[k] sits at wr_ptr-1-k.
    assign rd_idx  = wr_ptr - AW'(1) - tap;
    assign prod    = coefs[tap] * samples[rd_idx];

    assign acc_rnd = acc + RND;
    assign acc_shr = acc_rnd >>> COEFF_FRAC;
    assign sat     = (acc_shr > SAT_MAX) ? DATA_WIDTH'(SAT_MAX) :
                     (acc_shr < SAT_MIN) ? DATA_WIDTH'(SAT_MIN) :
                                           acc_shr[DATA_WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_out  = 1'b1;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (trigger) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (tap == AW'(NUM_TAPS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr           <= '0;
            tap              <= '0;
            phase            <= '0;
            acc              <= '0;
            dec_output       <= '0;
            dec_output_ready <= 1'b0;
            overrun_out      <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                samples[i] <= '0;
                coefs[i]   <= COEF_RESET;
            end
        end else begin
            dec_output_ready <= 1'b0;
            if (audio_sample_valid && (state != IDLE)) begin
                overrun_out <= 1'b1;
            end
            if (coef_wr) begin
                coefs[coef_addr_in] <= coef_data_in;
            end
            if (accept) begin
                samples[wr_ptr] <= audio_in;
                wr_ptr          <= wr_ptr + 1'b1;
                phase           <= trigger ? '0 : phase + 1'b1;
            end
            if (trigger) begin
                acc <= '0;
                tap <= '0;
            end
            if (state == MAC) begin
                acc <= acc + {{AW{prod[PW-1]}}, prod};
                tap <= tap + 1'b1;
            end
            if (state == DONE) begin
                dec_output       <= sat;
                dec_output_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decimator_mac.sv
// Directed bench: two 8-tap instances sharing stimulus, decimation 4 and decimation 1.
module tb_fir_decimator_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        coef_we;
    logic [15:0] audio;
    logic [15:0] coef_data;
    logic [2:0]  coef_addr;

    logic [15:0] o4, o1;
    logic        r4, r1, b4, b1, ov4, ov1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fir_decimator_mac #(.NUM_TAPS(8), .DECIMATION(4)) u_dec4 (
        .clk_in(clk), .rst_in(rst), .audio_in(audio), .audio_sample_valid(valid),
        .coef_we_in(coef_we), .coef_addr_in(coef_addr), .coef_data_in(coef_data),
        .dec_output(o4), .dec_output_ready(r4), .busy_out(b4), .overrun_out(ov4)
    );

    fir_decimator_mac #(.NUM_TAPS(8), .DECIMATION(1)) u_dec1 (
        .clk_in(clk), .rst_in(rst), .audio_in(audio), .audio_sample_valid(valid),
        .coef_we_in(coef_we), .coef_addr_in(coef_addr), .coef_data_in(coef_data),
        .dec_output(o1), .dec_output_ready(r1), .busy_out(b1), .overrun_out(ov1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_coef(input int addr, input int data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 16'(data);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // One sample, then 11 idle cycles of observation (12-cycle spacing).
    // kind: 0 none, 1 extra sample, 2 coefficient write, 3 reset pulse -- driven during cycle 'at'.
    task automatic step(input int v, input int kind, input int at, input int iv, input int ia,
                        input int e4, input int x4, input int e1, input int x1, input string tag);
        int n4, n1, c4, c1, v4, v1, bb4, bb1;
        n4 = 0; n1 = 0; c4 = -1; c1 = -1; v4 = 0; v1 = 0; bb4 = 0; bb1 = 0;
        @(negedge clk);
        audio = 16'(v);
        valid = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            valid   = 1'b0;
            coef_we = 1'b0;
            rst     = 1'b0;
            if (i == 1) begin
                bb4 = int'(b4);
                bb1 = int'(b1);
            end
            if (r4) begin
                if (n4 == 0) c4 = i;
                n4++;
                v4 = int'($signed(o4));
            end
            if (r1) begin
                if (n1 == 0) c1 = i;
                n1++;
                v1 = int'($signed(o1));
            end
            if (kind != 0 && i == at) begin
                if (kind == 1) begin
                    valid = 1'b1;
                    audio = 16'(iv);
                end else if (kind == 2) begin
                    coef_we   = 1'b1;
                    coef_addr = 3'(ia);
                    coef_data = 16'(iv);
                end else begin
                    rst = 1'b1;
                end
            end
        end
        chk({tag, " d4 busy"}, bb4, e4);
        chk({tag, " d1 busy"}, bb1, (kind == 3) ? 1 : e1);
        chk({tag, " d4 strobes"}, n4, e4);
        chk({tag, " d1 strobes"}, n1, e1);
        if (e4 != 0) begin
            chk({tag, " d4 latency"}, c4, 10);
            chk({tag, " d4 value"}, v4, x4);
        end
        if (e1 != 0) begin
            chk({tag, " d1 latency"}, c1, 10);
            chk({tag, " d1 value"}, v1, x1);
        end
    endtask

    task automatic run_s1(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step(1000, 0, 0, 0, 0, int'(k % 4 == 0), (k == 4) ? 500 : 1000, 1, 125 * k,
                 $sformatf("%s[%0d]", tag, k));
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 8; k++) load_coef(k, (k + 1) * 1024);
    endtask

    task automatic run_s2(input string tag);
        for (int k = 1; k <= 9; k++) begin
            step((k == 1) ? 320 : 0, 0, 0, 0, 0, int'(k % 4 == 0), (k == 4) ? 40 : 80,
                 1, (k <= 8) ? 10 * k : 0, $sformatf("%s[%0d]", tag, k));
        end
    endtask

    int neg1 [8] = '{32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};

    initial begin
        rst = 1'b1; valid = 1'b0; coef_we = 1'b0;
        audio = '0; coef_data = '0; coef_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset d4 out", $signed(o4), 0);
        chk("reset d4 rdy", r4, 0);
        chk("reset d4 busy", b4, 0);
        chk("reset d4 ovr", ov4, 0);
        chk("reset d1 out", $signed(o1), 0);
        chk("reset d1 ovr", ov1, 0);

        run_s1("avg");

        do_reset();
        load_ramp();
        run_s2("imp");

        do_reset();
        for (int k = 0; k < 8; k++) load_coef(k, 32767);
        for (int k = 1; k <= 8; k++) begin
            step(32767, 0, 0, 0, 0, int'(k % 4 == 0), 32767, 1, (k == 1) ? 32766 : 32767,
                 $sformatf("satp[%0d]", k));
        end
        for (int k = 1; k <= 8; k++) begin
            step(-32768, 0, 0, 0, 0, int'(k % 4 == 0), (k == 4) ? -4 : -32768, 1, neg1[k-1],
                 $sformatf("satn[%0d]", k));
        end

        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step(800, 0, 0, 0, 0, 0, 0, 1, 100 * k, $sformatf("ovr[%0d]", k));
        end
        chk("ovr clear d4", ov4, 0);
        step(800, 1, 3, 30000, 0, 1, 400, 1, 400, "ovr[4]");
        chk("ovr set d4", ov4, 1);
        chk("ovr set d1", ov1, 1);
        for (int k = 5; k <= 8; k++) begin
            step(800, 0, 0, 0, 0, int'(k == 8), 800, 1, 100 * k, $sformatf("ovr[%0d]", k));
        end
        chk("ovr sticky d4", ov4, 1);

        step(5000, 3, 4, 0, 0, 0, 0, 0, 0, "rstmid");
        chk("rstmid d4 out", $signed(o4), 0);
        chk("rstmid d1 out", $signed(o1), 0);
        chk("rstmid d4 ovr", ov4, 0);
        chk("rstmid d1 ovr", ov1, 0);
        chk("rstmid d1 busy", b1, 0);
        run_s1("rerun");

        do_reset();
        load_ramp();
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 0, $sformatf("cwb[%0d]", k));
        end
        step(0, 2, 3, 0, 0, 1, 0, 1, 0, "cwb[4]");
        run_s2("cwb_imp");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
